// File: rtl/pim_pkg.sv
// Shared definitions for the PIM result drain path: operation modes,
// drain FSM states and small mode-decode helpers.
package pim_pkg;

   localparam logic [2:0] PIM_READ     = 3'b011;
   localparam logic [2:0] PIM_PARALLEL = 3'b101;
   localparam logic [2:0] PIM_RBR      = 3'b110;

   localparam int DATA_W     = 32;
   localparam int LOAD_CNT_W = 5;
   localparam int WORD_CNT_W = 6;

   typedef enum logic [1:0] {
      DRAIN_IDLE   = 2'b00,
      DRAIN_LOAD   = 2'b01,
      DRAIN_FLUSH  = 2'b10,
      DRAIN_FINISH = 2'b11
   } drain_state_e;

   // True for modes whose result can be drained from the output buffer.
   function automatic logic mode_supported(input logic [2:0] mode);
      logic ok;
      case (mode)
         PIM_READ:     ok = 1'b1;
         PIM_PARALLEL: ok = 1'b1;
         PIM_RBR:      ok = 1'b1;
         default:      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // True for modes that drain every mapping group rather than one word.
   function automatic logic mode_is_grouped(input logic [2:0] mode);
      logic grouped;
      case (mode)
         PIM_PARALLEL: grouped = 1'b1;
         PIM_RBR:      grouped = 1'b1;
         default:      grouped = 1'b0;
      endcase
      return grouped;
   endfunction

endpackage

// File: rtl/pim_result_fifo.sv
// Small synchronous FIFO holding drained result words until the bus takes
// them. Head word is read straight from storage; pointers wrap modulo DEPTH.
module pim_result_fifo
   import pim_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          push_data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          pop_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign full_o     = (count_r == CNT_W'(DEPTH));
   assign empty_o    = (count_r == {CNT_W{1'b0}});
   assign count_o    = count_r;
   assign pop_data_o = mem_r[rd_ptr_r];
   assign push_ok_s  = push_i && !full_o;
   assign pop_ok_s   = pop_i && !empty_o;

   // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (clear_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Word storage; zeroed on reset so the head reads 0 out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (push_ok_s && !clear_i) begin
         mem_r[wr_ptr_r] <= push_data_i;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

endmodule

// File: rtl/pim_result_drain.sv
// Drain sequencer: walks the PIM output buffer with load_en/load_cnt after an
// operation completes, buffers the words and hands them to the bus through a
// valid/ready port. The walk pauses while the FIFO is full.
module pim_result_drain
   import pim_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int NUM_GROUPS = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [2:0]             mode_i,
   input  logic                   clear_i,
   output logic                   load_en_o,
   output logic [LOAD_CNT_W-1:0]  load_cnt_o,
   input  logic [DATA_W-1:0]      load_data_i,
   output logic                   rd_valid_o,
   input  logic                   rd_ready_i,
   output logic [DATA_W-1:0]      rd_data_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   mode_err_o
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   drain_state_e            state_r;
   logic [LOAD_CNT_W-1:0]   load_cnt_r;
   logic [WORD_CNT_W-1:0]   word_cnt_r;
   logic [WORD_CNT_W-1:0]   word_total_r;
   logic                    mode_err_r;

   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   logic [CNT_W-1:0]        fifo_count_s;
   logic                    load_en_s;
   logic                    last_push_s;

   // The walk advances only from registered state and the registered FIFO
   // occupancy, so nothing here depends on rd_ready_i in the same cycle.
   assign load_en_s   = (state_r == DRAIN_LOAD) && !fifo_full_s;
   assign last_push_s = load_en_s && (word_cnt_r == (word_total_r - WORD_CNT_W'(1)));

   assign load_en_o  = load_en_s;
   assign load_cnt_o = load_cnt_r;
   assign rd_valid_o = !fifo_empty_s;
   assign busy_o     = (state_r != DRAIN_IDLE);
   assign done_o     = (state_r == DRAIN_FINISH);
   assign mode_err_o = mode_err_r;

   pim_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .push_i      (load_en_s),
      .push_data_i (load_data_i),
      .pop_i       (rd_ready_i),
      .pop_data_o  (rd_data_o),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s),
      .count_o     (fifo_count_s)
   );

   // Drain FSM with load index, word counter and sticky mode error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= DRAIN_IDLE;
         load_cnt_r   <= {LOAD_CNT_W{1'b0}};
         word_cnt_r   <= {WORD_CNT_W{1'b0}};
         word_total_r <= {WORD_CNT_W{1'b0}};
         mode_err_r   <= 1'b0;
      end else if (clear_i) begin
         state_r      <= DRAIN_IDLE;
         load_cnt_r   <= {LOAD_CNT_W{1'b0}};
         word_cnt_r   <= {WORD_CNT_W{1'b0}};
         word_total_r <= {WORD_CNT_W{1'b0}};
         mode_err_r   <= 1'b0;
      end else begin
         case (state_r)
            DRAIN_IDLE: begin
               if (start_i && mode_supported(mode_i)) begin
                  state_r    <= DRAIN_LOAD;
                  word_cnt_r <= {WORD_CNT_W{1'b0}};
                  if (mode_is_grouped(mode_i)) begin
                     // Buffer selects group 31-load_cnt, so counting down
                     // from the top delivers group 0 first.
                     word_total_r <= WORD_CNT_W'(NUM_GROUPS);
                     load_cnt_r   <= LOAD_CNT_W'(NUM_GROUPS - 1);
                  end else begin
                     word_total_r <= WORD_CNT_W'(1);
                     load_cnt_r   <= {LOAD_CNT_W{1'b0}};
                  end
               end else if (start_i) begin
                  mode_err_r <= 1'b1;
               end else begin
                  state_r <= DRAIN_IDLE;
               end
            end
            DRAIN_LOAD: begin
               if (last_push_s) begin
                  state_r    <= DRAIN_FLUSH;
                  word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
                  load_cnt_r <= {LOAD_CNT_W{1'b0}};
               end else if (load_en_s) begin
                  word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
                  load_cnt_r <= load_cnt_r - LOAD_CNT_W'(1);
               end else begin
                  load_cnt_r <= load_cnt_r;
               end
            end
            DRAIN_FLUSH: begin
               if (fifo_count_s == {CNT_W{1'b0}}) begin
                  state_r <= DRAIN_FINISH;
               end else begin
                  state_r <= DRAIN_FLUSH;
               end
            end
            DRAIN_FINISH: begin
               state_r <= DRAIN_IDLE;
            end
            default: begin
               state_r <= DRAIN_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pim_result_drain.sv
// Self-checking bench for pim_result_drain. A reference model tracks pushes
// and pops as plain counts and predicts the expected word stream per drain.
module tb_pim_result_drain;
   import pim_pkg::*;

   localparam int DEPTH = 8;
   localparam int NG    = 32;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  mode_i = 3'b000;
   logic        clear_i = 1'b0;
   logic        load_en_o;
   logic [4:0]  load_cnt_o;
   logic [31:0] load_data_i;
   logic        rd_valid_o;
   logic        rd_ready_i = 1'b0;
   logic [31:0] rd_data_o;
   logic        busy_o;
   logic        done_o;
   logic        mode_err_o;

   logic [31:0] bufm [0:31];
   logic        read_sel = 1'b0;
   logic [31:0] read_word = 32'h0;
   logic [4:0]  grp_idx;

   int checks = 0;
   int errors = 0;
   int dc;

   pim_result_drain #(.DEPTH(DEPTH), .NUM_GROUPS(NG)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .mode_i      (mode_i),
      .clear_i     (clear_i),
      .load_en_o   (load_en_o),
      .load_cnt_o  (load_cnt_o),
      .load_data_i (load_data_i),
      .rd_valid_o  (rd_valid_o),
      .rd_ready_i  (rd_ready_i),
      .rd_data_o   (rd_data_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .mode_err_o  (mode_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Output buffer model: group 31-load_cnt, or the single read word.
   assign grp_idx     = 5'd31 - load_cnt_o;
   assign load_data_i = read_sel ? read_word : bufm[grp_idx];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_load_en"}, 32'(load_en_o), 32'd0);
      check({tag, "_rd_valid"}, 32'(rd_valid_o), 32'd0);
      check({tag, "_done"}, 32'(done_o), 32'd0);
   endtask

   // One complete drain: start in cycle 0, then predict every cycle from
   // push/pop counts until the done pulse.
   task automatic drain(input logic [2:0] mode, input int stall, input bit rand_ready,
                        input bit noise, output int done_cyc);
      logic [31:0] expq [$];
      int total, pushes, pops, occ;
      bit exp_en, flushed, exp_done, fin, rdy;
      total = (mode == PIM_READ) ? 1 : NG;
      for (int g = 0; g < total; g++) expq.push_back((mode == PIM_READ) ? read_word : bufm[g]);
      pushes = 0; pops = 0; flushed = 0; fin = 0; done_cyc = -1;
      start_i = 1'b1; mode_i = mode; rd_ready_i = 1'b0;
      tick();
      for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
         rdy = (cyc <= stall) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         rd_ready_i = rdy;
         start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         mode_i = 3'($urandom_range(0, 7));
         occ = pushes - pops;
         exp_en = (pushes < total) && (occ < DEPTH);
         exp_done = flushed;
         check("load_en", 32'(load_en_o), 32'(exp_en));
         if (exp_en) check("load_cnt", 32'(load_cnt_o), (mode == PIM_READ) ? 32'd0 : 32'(31 - pushes));
         check("rd_valid", 32'(rd_valid_o), 32'(occ > 0));
         check("busy", 32'(busy_o), 32'd1);
         check("done", 32'(done_o), 32'(exp_done));
         check("mode_err", 32'(mode_err_o), 32'd0);
         if (occ > 0 && rdy) begin
            check("rd_data", rd_data_o, expq[pops]);
            pops++;
         end
         if (exp_done) begin
            fin = 1'b1; done_cyc = cyc; start_i = 1'b0;
         end else if (pushes == total && occ == 0) begin
            flushed = 1'b1;
         end
         if (exp_en) pushes++;
         tick();
      end
      start_i = 1'b0;
      rd_ready_i = 1'b0;
      if (!fin) check("drain_timeout", 32'(done_o), 32'd1);
      check_idle("after_done");
   endtask

   initial begin
      for (int g = 0; g < NG; g++) bufm[g] = 32'hA000_0000 + 32'(g);

      // Reset values.
      tick();
      check("rst_load_cnt", 32'(load_cnt_o), 32'd0);
      check("rst_rd_data", rd_data_o, 32'd0);
      check("rst_mode_err", 32'(mode_err_o), 32'd0);
      check_idle("rst");
      rst_ni = 1'b1;
      tick();

      // Parallel drain, consumer always ready: done must land in cycle 35.
      drain(PIM_PARALLEL, 0, 1'b0, 1'b0, dc);
      check("par_done_cycle", 32'(dc), 32'd35);

      // Read mode: one word at index 0.
      read_sel = 1'b1; read_word = 32'hDEAD_BEEF;
      drain(PIM_READ, 0, 1'b0, 1'b0, dc);
      check("read_done_cycle", 32'(dc), 32'd4);
      read_sel = 1'b0;

      // RBR with 20 stalled cycles: walk pauses at full, nothing lost.
      for (int g = 0; g < NG; g++) bufm[g] = $urandom;
      drain(PIM_RBR, 20, 1'b0, 1'b0, dc);

      // Random backpressure with stray start pulses while busy.
      for (int r = 0; r < 3; r++) begin
         for (int g = 0; g < NG; g++) bufm[g] = $urandom;
         drain((r % 2 == 0) ? PIM_PARALLEL : PIM_RBR, 0, 1'b1, 1'b1, dc);
      end

      // Unsupported mode: stays idle, error sticks until clear.
      start_i = 1'b1; mode_i = 3'b001;
      tick();
      start_i = 1'b0;
      check("bad_mode_busy", 32'(busy_o), 32'd0);
      check("bad_mode_err", 32'(mode_err_o), 32'd1);
      tick();
      check("bad_mode_sticky", 32'(mode_err_o), 32'd1);
      clear_i = 1'b1; start_i = 1'b1; mode_i = PIM_PARALLEL;
      tick();
      clear_i = 1'b0; start_i = 1'b0;
      check("clear_err", 32'(mode_err_o), 32'd0);
      check_idle("clear_beats_start");

      // Reset in the middle of a drain.
      for (int g = 0; g < NG; g++) bufm[g] = $urandom;
      start_i = 1'b1; mode_i = PIM_PARALLEL; rd_ready_i = 1'b0;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 10; c++) begin rd_ready_i = 1'b1; tick(); end
      check("pre_rst_busy", 32'(busy_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("mid_rst_load_cnt", 32'(load_cnt_o), 32'd0);
      check("mid_rst_rd_data", rd_data_o, 32'd0);
      check("mid_rst_mode_err", 32'(mode_err_o), 32'd0);
      check_idle("mid_rst");
      rd_ready_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      check_idle("post_rst");
      drain(PIM_PARALLEL, 0, 1'b1, 1'b0, dc);

      // Clear in the middle of a stalled drain.
      start_i = 1'b1; mode_i = PIM_RBR; rd_ready_i = 1'b0;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      check("pre_clear_valid", 32'(rd_valid_o), 32'd1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check_idle("mid_clear");
      tick();
      check_idle("mid_clear_hold");
      for (int g = 0; g < NG; g++) bufm[g] = $urandom;
      drain(PIM_RBR, 5, 1'b1, 1'b0, dc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
